// File: rtl/bf_pkg.sv
// Shared types and constants for the bit-serial fused multiplier.
// Holds the precision-mode and FSM state enums, the datapath widths, and
// small helpers that turn a precision mode into a 2-bit brick count.
package bf_pkg;

  localparam int BRICK_W = 2;
  localparam int BPROD_W = 6;
  localparam int OP_W    = 8;
  localparam int ACC_W   = 17;

  typedef enum logic [1:0] {
    MODE2 = 2'd0,
    MODE4 = 2'd1,
    MODE8 = 2'd2
  } prec_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } fuse_state_t;

  // The reserved encoding 2'b11 is treated as full 8-bit precision.
  function automatic prec_mode_t decode_mode(input logic [1:0] m);
    prec_mode_t r;
    case (m)
      2'd0:    r = MODE2;
      2'd1:    r = MODE4;
      default: r = MODE8;
    endcase
    return r;
  endfunction

  // Number of 2-bit bricks in an operand of the given precision.
  function automatic logic [2:0] brick_count(input prec_mode_t m);
    logic [2:0] r;
    case (m)
      MODE2:   r = 3'd1;
      MODE4:   r = 3'd2;
      default: r = 3'd4;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bit_brick.sv
// Signed/unsigned 2b x 2b multiplier brick.
// Ports:
//   a, b   : 2-bit operand bricks
//   sa, sb : 1 = the brick is the top brick of a two's complement operand
//   p      : 6-bit signed product
module bit_brick
  import bf_pkg::*;
(
  input  logic [BRICK_W-1:0]        a,
  input  logic [BRICK_W-1:0]        b,
  input  logic                      sa,
  input  logic                      sb,
  output logic signed [BPROD_W-1:0] p
);

  logic signed [BRICK_W:0] a_ext;
  logic signed [BRICK_W:0] b_ext;

  // A signed brick extends with its msb, an unsigned one with zero, so a
  // single signed 3x3 multiply covers all four sign combinations.
  assign a_ext = {sa & a[BRICK_W-1], a};
  assign b_ext = {sb & b[BRICK_W-1], b};
  assign p     = a_ext * b_ext;

endmodule

// File: rtl/bit_serial_fuse.sv
// Bit-serial fused-precision multiplier.
// Multiplies a 2/4/8-bit activation by a 2/4/8-bit weight, signed or
// unsigned each, by walking one 2b x 2b brick pair per cycle through a
// single bit_brick and accumulating the shifted partial products.
// Ports:
//   clk, RST             : clock and synchronous active-high reset
//   in_valid / in_ready  : operand handshake (x, y, sx, sy, mode_x, mode_y)
//   out_valid / out_ready: result handshake
//   product              : 17-bit signed full-precision product
module bit_serial_fuse
  import bf_pkg::*;
(
  input  logic                    clk,
  input  logic                    RST,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [OP_W-1:0]         x,
  input  logic [OP_W-1:0]         y,
  input  logic                    sx,
  input  logic                    sy,
  input  logic [1:0]              mode_x,
  input  logic [1:0]              mode_y,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] product
);

  fuse_state_t      state_q, state_d;
  logic [3:0]       k_q, k_d;
  logic [OP_W-1:0]  x_q, x_d, y_q, y_d;
  logic             sx_q, sx_d, sy_q, sy_d;
  prec_mode_t       mode_x_q, mode_x_d, mode_y_q, mode_y_d;
  logic [ACC_W-1:0] acc_q, acc_d;

  logic [2:0]               nx, ny;
  logic [4:0]               n_last;
  logic [1:0]               bi, bj;
  logic [2:0]               shift_sum;
  logic [BRICK_W-1:0]       x_brick, y_brick;
  logic                     x_top, y_top;
  logic signed [BPROD_W-1:0] bprod;
  logic [ACC_W-1:0]         term;

  assign nx     = brick_count(mode_x_q);
  assign ny     = brick_count(mode_y_q);
  assign n_last = 5'(nx) * 5'(ny) - 5'd1;

  // nx is a power of two, so k mod nx and k div nx are plain bit fields of k.
  always_comb begin
    bi = 2'd0;
    bj = 2'd0;
    case (mode_x_q)
      MODE2: begin
        bi = 2'd0;
        bj = k_q[1:0];
      end
      MODE4: begin
        bi = {1'b0, k_q[0]};
        bj = k_q[2:1];
      end
      default: begin
        bi = k_q[1:0];
        bj = k_q[3:2];
      end
    endcase
  end

  // Only the most significant brick of a signed operand carries the sign.
  assign x_brick = x_q[{bi, 1'b0} +: BRICK_W];
  assign y_brick = y_q[{bj, 1'b0} +: BRICK_W];
  assign x_top   = ({1'b0, bi} == nx - 3'd1);
  assign y_top   = ({1'b0, bj} == ny - 3'd1);

  bit_brick u_brick (
    .a  (x_brick),
    .b  (y_brick),
    .sa (sx_q & x_top),
    .sb (sy_q & y_top),
    .p  (bprod)
  );

  assign shift_sum = {1'b0, bi} + {1'b0, bj};
  assign term      = {{(ACC_W-BPROD_W){bprod[BPROD_W-1]}}, bprod} << {shift_sum, 1'b0};

  // Next-state, operand capture and accumulation.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    x_d      = x_q;
    y_d      = y_q;
    sx_d     = sx_q;
    sy_d     = sy_q;
    mode_x_d = mode_x_q;
    mode_y_d = mode_y_q;
    acc_d    = acc_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d      = x;
          y_d      = y;
          sx_d     = sx;
          sy_d     = sy;
          mode_x_d = decode_mode(mode_x);
          mode_y_d = decode_mode(mode_y);
          acc_d    = '0;
          k_d      = 4'd0;
          state_d  = CALC;
        end
      end
      CALC: begin
        acc_d = acc_q + term;
        if ({1'b0, k_q} == n_last) begin
          k_d     = 4'd0;
          state_d = DONE;
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q  <= IDLE;
      k_q      <= '0;
      x_q      <= '0;
      y_q      <= '0;
      sx_q     <= 1'b0;
      sy_q     <= 1'b0;
      mode_x_q <= MODE2;
      mode_y_q <= MODE2;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      x_q      <= x_d;
      y_q      <= y_d;
      sx_q     <= sx_d;
      sy_q     <= sy_d;
      mode_x_q <= mode_x_d;
      mode_y_q <= mode_y_d;
      acc_q    <= acc_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign product   = acc_q;

endmodule

// File: tb/tb_bit_serial_fuse.sv
// Self-checking bench for bit_serial_fuse.
// Expected products come from a plain integer model of the operands and are
// queued together with the expected latency when an operand pair is driven;
// they are popped and compared when the DUT raises out_valid.
module tb_bit_serial_fuse;

  logic        clk = 1'b0;
  logic        RST;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  x;
  logic [7:0]  y;
  logic        sx;
  logic        sy;
  logic [1:0]  mode_x;
  logic [1:0]  mode_y;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] product;

  int testsRun    = 0;
  int testsFailed = 0;
  int expQ[$];
  int latQ[$];

  bit_serial_fuse dut (
    .clk       (clk),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .sx        (sx),
    .sy        (sy),
    .mode_x    (mode_x),
    .mode_y    (mode_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Integer value of the low w bits of an operand, optionally two's complement.
  function automatic int opValue(input logic [7:0] v, input logic s, input logic [1:0] m);
    int w;
    int val;
    w   = (m == 2'd0) ? 2 : (m == 2'd1) ? 4 : 8;
    val = int'(v) & ((1 << w) - 1);
    if (s && val[w-1]) val = val - (1 << w);
    return val;
  endfunction

  function automatic int brickCount(input logic [1:0] m);
    return (m == 2'd0) ? 1 : (m == 2'd1) ? 2 : 4;
  endfunction

  // Presents one operand pair until accepted. When pushExp is set the model
  // result and the expected latency (cycles from the accept cycle, inclusive,
  // to the first out_valid cycle) are queued.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic sa, input logic sb,
                               input logic [1:0] ma, input logic [1:0] mb,
                               input bit pushExp);
    bit accepted = 1'b0;
    int waitCnt  = 0;
    if (pushExp) begin
      expQ.push_back(opValue(a, sa, ma) * opValue(b, sb, mb));
      latQ.push_back(brickCount(ma) * brickCount(mb) + 1);
    end
    x        = a;
    y        = b;
    sx       = sa;
    sy       = sb;
    mode_x   = ma;
    mode_y   = mb;
    in_valid = 1'b1;
    while (!accepted && waitCnt < 50) begin
      accepted = in_ready;
      @(posedge clk);
      #1;
      waitCnt++;
    end
    in_valid = 1'b0;
    // Scramble the inputs so a design that keeps sampling them is caught.
    x      = 8'($urandom);
    y      = 8'($urandom);
    sx     = 1'($urandom);
    sy     = 1'($urandom);
    mode_x = 2'($urandom);
    mode_y = 2'($urandom);
    if (!accepted) checkOutput("accept_timeout", 0, 1);
  endtask

  // Called #1 after the accept edge. Waits for out_valid, checks the result,
  // optionally stalls the consumer, then completes the handoff.
  task automatic collectResult(input string tag, input int holdCycles);
    int cycles = 1;
    int expP;
    int expL;
    int p;
    while (!out_valid && cycles < 100) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    if (expQ.size() == 0) begin
      checkOutput({tag, "_queue"}, 0, 1);
      return;
    end
    expP = expQ.pop_front();
    expL = latQ.pop_front();
    p    = $signed(product);
    checkOutput({tag, "_valid"}, int'(out_valid), 1);
    checkOutput({tag, "_latency"}, cycles, expL);
    checkOutput({tag, "_product"}, p, expP);
    for (int h = 0; h < holdCycles; h++) begin
      @(posedge clk);
      #1;
      p = $signed(product);
      checkOutput({tag, "_hold_valid"}, int'(out_valid), 1);
      checkOutput({tag, "_hold_product"}, p, expP);
      checkOutput({tag, "_hold_in_ready"}, int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput({tag, "_release_valid"}, int'(out_valid), 0);
    checkOutput({tag, "_release_in_ready"}, int'(in_ready), 1);
  endtask

  initial begin
    int outSeen;
    int p;
    RST       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x         = 8'd0;
    y         = 8'd0;
    sx        = 1'b0;
    sy        = 1'b0;
    mode_x    = 2'd0;
    mode_y    = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    p = $signed(product);
    checkOutput("reset_in_ready", int'(in_ready), 1);
    checkOutput("reset_out_valid", int'(out_valid), 0);
    checkOutput("reset_product", p, 0);

    // An operand pair presented together with reset must be dropped.
    in_valid = 1'b1;
    x        = 8'h55;
    y        = 8'h33;
    @(posedge clk);
    #1;
    RST      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_accept_in_ready", int'(in_ready), 1);
    checkOutput("rst_accept_out_valid", int'(out_valid), 0);

    // Directed corner cases.
    applyStimulus(8'h80, 8'h80, 1'b1, 1'b1, 2'd2, 2'd2, 1'b1);
    collectResult("s8x8_min", 0);
    applyStimulus(8'hFF, 8'hFF, 1'b0, 1'b0, 2'd2, 2'd2, 1'b1);
    collectResult("u8x8_max", 0);
    applyStimulus(8'hFF, 8'h7F, 1'b1, 1'b0, 2'd2, 2'd2, 1'b1);
    collectResult("mixed8x8", 0);
    applyStimulus(8'hFE, 8'hFF, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1);
    collectResult("s2x2", 0);
    applyStimulus(8'hF9, 8'd100, 1'b1, 1'b0, 2'd1, 2'd2, 1'b1);
    collectResult("s4x8", 0);
    applyStimulus(8'h9C, 8'h37, 1'b1, 1'b1, 2'd3, 2'd3, 1'b1);
    collectResult("mode11", 0);
    applyStimulus(8'hA7, 8'hC3, 1'b1, 1'b1, 2'd2, 2'd1, 1'b1);
    collectResult("backpressure", 5);

    // Random operand pairs across all modes and signedness.
    for (int r = 0; r < 8; r++) begin
      applyStimulus(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                    2'($urandom), 2'($urandom), 1'b1);
      collectResult("random", r % 3);
    end

    // Reset in the middle of an 8b x 8b calculation: k reaches 3 after three
    // calculation edges, then reset is applied for one edge.
    applyStimulus(8'h6B, 8'h91, 1'b0, 1'b1, 2'd2, 2'd2, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    RST = 1'b1;
    @(posedge clk);
    #1;
    RST = 1'b0;
    checkOutput("abort_in_ready", int'(in_ready), 1);
    checkOutput("abort_out_valid", int'(out_valid), 0);
    outSeen = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) outSeen++;
    end
    checkOutput("abort_no_output", outSeen, 0);
    applyStimulus(8'd3, 8'd5, 1'b0, 1'b0, 2'd0, 2'd1, 1'b1);
    collectResult("after_abort", 0);

    checkOutput("queue_empty", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
